// File: rtl/video_mon.sv
// Video timing monitor: measures active width, active height and total line
// count of each frame, and publishes them once several consecutive frames
// agree. Publication is withdrawn on bad frames, on a format change and when
// vertical sync disappears for too long.
module video_mon #(
    parameter int STABLE_FRAMES = 2,
    parameter int TIMEOUT_W     = 20
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       ce_pix,
    input  logic       hs,
    input  logic       vs,
    input  logic       hbl,
    input  logic       vbl,
    output logic [9:0] width,
    output logic [9:0] height,
    output logic [9:0] lines_total,
    output logic       valid,
    output logic       changed
);

    localparam int            SW       = $clog2(STABLE_FRAMES + 1);
    localparam logic [SW-1:0] STAB_MAX = SW'(STABLE_FRAMES);
    localparam logic [SW-1:0] STAB_ONE = SW'(1);
    localparam logic [9:0]    CNT_MAX  = 10'd1023;

    typedef enum logic {
        SYNC_WAIT,
        MEASURE
    } state_t;

    state_t               state;
    logic                 hs_q;
    logic                 vs_q;
    logic                 hbl_q;
    logic [9:0]           pix_cnt;
    logic [9:0]           line_w;
    logic [9:0]           act_lines;
    logic [9:0]           tot_lines;
    logic                 irregular;
    logic [9:0]           prev_w;
    logic [9:0]           prev_h;
    logic [9:0]           prev_t;
    logic [SW-1:0]        stab_cnt;
    logic [TIMEOUT_W-1:0] timeout_cnt;

    logic                 frame_end;
    logic                 line_start;
    logic                 line_end;
    logic                 pix_en;
    logic                 line_counted;
    logic                 timeout_hit;
    logic [9:0]           line_w_nxt;
    logic [9:0]           act_nxt;
    logic [9:0]           tot_nxt;
    logic                 irregular_nxt;
    logic                 cand_bad;
    logic                 same_prev;
    logic                 same_pub;
    logic [SW-1:0]        stab_nxt;

    // Edge detection and the per-frame statistics including the current clk's line, so a line ending with the frame still counts
    always_comb begin
        frame_end     = vs_q & ~vs;
        line_start    = hs_q & ~hs;
        line_end      = ~hbl_q & hbl;
        pix_en        = ce_pix & ~hbl & ~vbl;
        timeout_hit   = (&timeout_cnt) & ~frame_end;
        line_counted  = line_end & (pix_cnt != 10'd0);
        line_w_nxt    = line_w;
        act_nxt       = act_lines;
        irregular_nxt = irregular;
        if (line_counted) begin
            if (act_lines == 10'd0) begin
                line_w_nxt = pix_cnt;
            end else if (pix_cnt != line_w) begin
                irregular_nxt = 1'b1;
            end
            if (act_lines != CNT_MAX) begin
                act_nxt = act_lines + 10'd1;
            end
        end
        tot_nxt = tot_lines;
        if (line_start && (tot_lines != CNT_MAX)) begin
            tot_nxt = tot_lines + 10'd1;
        end
        cand_bad  = irregular_nxt | (act_nxt == 10'd0);
        same_prev = ({line_w_nxt, act_nxt, tot_lines} == {prev_w, prev_h, prev_t});
        same_pub  = ({line_w_nxt, act_nxt, tot_lines} == {width, height, lines_total});
        if (!same_prev) begin
            stab_nxt = STAB_ONE;
        end else if (stab_cnt == STAB_MAX) begin
            stab_nxt = STAB_MAX;
        end else begin
            stab_nxt = stab_cnt + STAB_ONE;
        end
    end

    // Previous-clk copies of the syncs and blanking for edge detection
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hs_q  <= 1'b0;
            vs_q  <= 1'b0;
            hbl_q <= 1'b0;
        end else begin
            hs_q  <= hs;
            vs_q  <= vs;
            hbl_q <= hbl;
        end
    end

    // Watchdog counting clks since the last vsync falling edge
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            timeout_cnt <= '0;
        end else if (frame_end) begin
            timeout_cnt <= '0;
        end else begin
            timeout_cnt <= timeout_cnt + 1'b1;
        end
    end

    // Measurement FSM: per-frame counters, candidate stability tracking and the published outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= SYNC_WAIT;
            pix_cnt     <= '0;
            line_w      <= '0;
            act_lines   <= '0;
            tot_lines   <= '0;
            irregular   <= 1'b0;
            prev_w      <= '0;
            prev_h      <= '0;
            prev_t      <= '0;
            stab_cnt    <= '0;
            width       <= '0;
            height      <= '0;
            lines_total <= '0;
            valid       <= 1'b0;
            changed     <= 1'b0;
        end else begin
            changed <= 1'b0;
            if (timeout_hit) begin
                state    <= SYNC_WAIT;
                valid    <= 1'b0;
                stab_cnt <= '0;
            end else begin
                case (state)
                    SYNC_WAIT: begin
                        if (frame_end) begin
                            state     <= MEASURE;
                            pix_cnt   <= '0;
                            line_w    <= '0;
                            act_lines <= '0;
                            irregular <= 1'b0;
                            tot_lines <= {9'd0, line_start};
                        end
                    end
                    MEASURE: begin
                        if (frame_end) begin
                            if (cand_bad) begin
                                stab_cnt <= '0;
                                valid    <= 1'b0;
                            end else begin
                                stab_cnt <= stab_nxt;
                                if (!same_prev) begin
                                    prev_w <= line_w_nxt;
                                    prev_h <= act_nxt;
                                    prev_t <= tot_lines;
                                end
                                if (stab_nxt == STAB_MAX) begin
                                    width       <= line_w_nxt;
                                    height      <= act_nxt;
                                    lines_total <= tot_lines;
                                    valid       <= 1'b1;
                                    changed     <= ~same_pub;
                                end else if (!same_pub) begin
                                    valid <= 1'b0;
                                end
                            end
                            pix_cnt   <= '0;
                            line_w    <= '0;
                            act_lines <= '0;
                            irregular <= 1'b0;
                            tot_lines <= {9'd0, line_start};
                        end else begin
                            if (line_end) begin
                                pix_cnt <= '0;
                            end else if (pix_en && (pix_cnt != CNT_MAX)) begin
                                pix_cnt <= pix_cnt + 10'd1;
                            end
                            line_w    <= line_w_nxt;
                            act_lines <= act_nxt;
                            irregular <= irregular_nxt;
                            tot_lines <= tot_nxt;
                        end
                    end
                    default: state <= SYNC_WAIT;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_video_mon.sv
// Testbench for video_mon: drives small synthetic frames (scaled-down
// geometry so the run stays short), keeps a frame-level model of what must be
// published, compares every clk, and pins the model with literal expectations.
module tb_video_mon;

    localparam int STABLE = 2;
    localparam int TW     = 10;
    localparam int TO_CYC = 1 << TW;

    typedef struct {
        int nlines;
        int vstart;
        int nact;
        int npix;
        int odd_idx;
        int odd_pix;
        bit tight;
    } frame_t;

    logic       clk     = 1'b0;
    logic       reset_n = 1'b0;
    logic       ce_pix  = 1'b0;
    logic       hs      = 1'b1;
    logic       vs      = 1'b1;
    logic       hbl     = 1'b1;
    logic       vbl     = 1'b1;
    logic [9:0] width;
    logic [9:0] height;
    logic [9:0] lines_total;
    logic       valid;
    logic       changed;

    int checks_total  = 0;
    int checks_passed = 0;

    logic [9:0] exp_w;
    logic [9:0] exp_h;
    logic [9:0] exp_t;
    logic       exp_valid;
    logic       exp_changed;
    int         prev_w;
    int         prev_h;
    int         prev_t;
    int         stab;
    bit         armed;
    bit         last_vs;
    int         since;
    int         cur_w;
    int         cur_a;
    int         cur_t;
    bit         cur_irr;
    bit         ce_tog = 1'b0;

    frame_t fa;
    frame_t fb;
    frame_t fbirr;
    frame_t fz;
    frame_t fc;

    video_mon #(
        .STABLE_FRAMES(STABLE),
        .TIMEOUT_W    (TW)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .ce_pix     (ce_pix),
        .hs         (hs),
        .vs         (vs),
        .hbl        (hbl),
        .vbl        (vbl),
        .width      (width),
        .height     (height),
        .lines_total(lines_total),
        .valid      (valid),
        .changed    (changed)
    );

    // Free-running video clock
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks_total++;
        if (actual == expected) begin
            checks_passed++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic pin_check(input string tag, input int pw, input int ph, input int pt,
                             input int pv, input int pc);
        checkOutput({tag, " width"}, int'(width), pw);
        checkOutput({tag, " height"}, int'(height), ph);
        checkOutput({tag, " lines_total"}, int'(lines_total), pt);
        checkOutput({tag, " valid"}, int'(valid), pv);
        checkOutput({tag, " changed"}, int'(changed), pc);
    endtask

    task automatic model_reset();
        exp_w       = '0;
        exp_h       = '0;
        exp_t       = '0;
        exp_valid   = 1'b0;
        exp_changed = 1'b0;
        prev_w      = 0;
        prev_h      = 0;
        prev_t      = 0;
        stab        = 0;
        armed       = 1'b0;
        last_vs     = 1'b0;
        since       = 0;
    endtask

    // Publication rules applied to the frame that just ended (cur_*)
    task automatic model_frame_end();
        bit differs_pub;
        if (!armed) begin
            armed = 1'b1;
        end else if (cur_irr || cur_a == 0) begin
            stab      = 0;
            exp_valid = 1'b0;
        end else begin
            if (cur_w == prev_w && cur_a == prev_h && cur_t == prev_t) begin
                stab = (stab < STABLE) ? stab + 1 : STABLE;
            end else begin
                stab   = 1;
                prev_w = cur_w;
                prev_h = cur_a;
                prev_t = cur_t;
            end
            differs_pub = (cur_w != int'(exp_w)) || (cur_a != int'(exp_h)) || (cur_t != int'(exp_t));
            if (stab == STABLE) begin
                exp_changed = differs_pub;
                exp_w       = 10'(cur_w);
                exp_h       = 10'(cur_a);
                exp_t       = 10'(cur_t);
                exp_valid   = 1'b1;
            end else if (differs_pub) begin
                exp_valid = 1'b0;
            end
        end
    endtask

    // Drives one clk of video and advances the model for that clk
    task automatic applyStimulus(input logic hs_v, input logic vs_v, input logic hbl_v, input logic vbl_v);
        @(negedge clk);
        ce_tog      = ~ce_tog;
        ce_pix      = ce_tog;
        hs          = hs_v;
        vs          = vs_v;
        hbl         = hbl_v;
        vbl         = vbl_v;
        exp_changed = 1'b0;
        if (last_vs && !vs_v) begin
            since = 0;
            model_frame_end();
        end else begin
            since++;
            if (since % TO_CYC == 0) begin
                exp_valid = 1'b0;
                stab      = 0;
                armed     = 1'b0;
            end
        end
        last_vs = vs_v;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset_n = 1'b0;
        model_reset();
        #1;
        pin_check("async reset", 0, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        @(posedge clk);
        #2;
        reset_n = 1'b1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
        end
    endtask

    // One frame: vs low for lines 0-1, hs low 2 clks at each line start, pixel
    // region of 2*npix clks with ce_pix every other clk, 2 trailing blank clks
    // (omitted on the last line of a tight frame so its line end lands on the next frame end)
    task automatic send_frame(input frame_t f, input int reset_line, input bit pin, input string tag,
                              input int pw, input int ph, input int pt, input int pv, input int pc);
        int  line_pix[64];
        int  w;
        int  a;
        bit  irr;
        int  reg_len;
        bit  blank;
        logic v;
        w   = 0;
        a   = 0;
        irr = 1'b0;
        for (int l = 0; l < f.nlines; l++) begin
            if (l >= f.vstart && l < f.vstart + f.nact) begin
                line_pix[l] = (l - f.vstart == f.odd_idx) ? f.odd_pix : f.npix;
            end else begin
                line_pix[l] = 0;
            end
            if (line_pix[l] > 0) begin
                if (a == 0) begin
                    w = line_pix[l];
                end else if (line_pix[l] != w) begin
                    irr = 1'b1;
                end
                a++;
            end
        end
        for (int l = 0; l < f.nlines; l++) begin
            if (l == reset_line) begin
                pulse_reset();
            end
            v       = (l < 2) ? 1'b0 : 1'b1;
            blank   = (line_pix[l] == 0);
            reg_len = blank ? f.npix : line_pix[l];
            for (int c = 0; c < 2; c++) begin
                applyStimulus(1'b0, v, 1'b1, blank);
                if (l == 0 && c == 0) begin
                    cur_w   = w;
                    cur_a   = a;
                    cur_t   = f.nlines;
                    cur_irr = irr;
                    if (pin) begin
                        @(posedge clk);
                        #1;
                        pin_check(tag, pw, ph, pt, pv, pc);
                    end
                end
            end
            for (int c = 0; c < 2; c++) begin
                applyStimulus(1'b1, v, 1'b1, blank);
            end
            for (int c = 0; c < 2 * reg_len; c++) begin
                applyStimulus(1'b1, v, 1'b0, blank);
            end
            if (!(f.tight && l == f.nlines - 1)) begin
                for (int c = 0; c < 2; c++) begin
                    applyStimulus(1'b1, v, 1'b1, blank);
                end
            end
        end
    endtask

    // Every-clk comparison of the DUT against the model
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (reset_n) begin
                checks_total++;
                if ({width, height, lines_total, valid, changed} ===
                    {exp_w, exp_h, exp_t, exp_valid, exp_changed}) begin
                    checks_passed++;
                end else begin
                    $display("[TB] FAIL cycle t=%0t: got w=%0d h=%0d t=%0d v=%0b c=%0b, expected w=%0d h=%0d t=%0d v=%0b c=%0b",
                             $time, width, height, lines_total, valid, changed,
                             exp_w, exp_h, exp_t, exp_valid, exp_changed);
                end
            end
        end
    end

    // Directed scenario sequence
    initial begin
        fa    = '{9, 3, 5, 12, -1, 0, 1'b0};
        fb    = '{9, 3, 5, 10, -1, 0, 1'b0};
        fbirr = '{9, 3, 5, 10, 2, 9, 1'b0};
        fz    = '{9, 3, 0, 10, -1, 0, 1'b0};
        fc    = '{9, 3, 6, 8, -1, 0, 1'b1};
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        pin_check("reset", 0, 0, 0, 0, 0);
        @(posedge clk);
        #2;
        reset_n = 1'b1;
        idle(10);

        $display("[TB] first lock on 12x5/9");
        send_frame(fa, -1, 1'b0, "", 0, 0, 0, 0, 0);
        send_frame(fa, -1, 1'b0, "", 0, 0, 0, 0, 0);
        send_frame(fa, -1, 1'b1, "lock A", 12, 5, 9, 1, 1);
        send_frame(fa, -1, 1'b1, "repeat A", 12, 5, 9, 1, 0);

        $display("[TB] format switch to 10 pixels");
        send_frame(fb, -1, 1'b1, "repeat A2", 12, 5, 9, 1, 0);
        send_frame(fb, -1, 1'b1, "first B", 12, 5, 9, 0, 0);
        send_frame(fbirr, -1, 1'b1, "lock B", 10, 5, 9, 1, 1);

        $display("[TB] irregular line and empty frame");
        send_frame(fb, -1, 1'b1, "irregular", 10, 5, 9, 0, 0);
        send_frame(fb, -1, 1'b1, "clean 1", 10, 5, 9, 0, 0);
        send_frame(fz, -1, 1'b1, "republish", 10, 5, 9, 1, 0);
        send_frame(fb, -1, 1'b1, "no active", 10, 5, 9, 0, 0);
        send_frame(fb, -1, 1'b1, "clean 1b", 10, 5, 9, 0, 0);
        send_frame(fb, -1, 1'b1, "republish b", 10, 5, 9, 1, 0);

        $display("[TB] vsync loss");
        idle(TO_CYC + 40);
        @(posedge clk);
        #1;
        pin_check("timeout", 10, 5, 9, 0, 0);
        send_frame(fb, -1, 1'b0, "", 0, 0, 0, 0, 0);
        send_frame(fb, -1, 1'b1, "relock 1", 10, 5, 9, 0, 0);
        send_frame(fb, -1, 1'b1, "relock 2", 10, 5, 9, 1, 0);

        $display("[TB] reset mid-frame");
        send_frame(fb, 4, 1'b0, "", 0, 0, 0, 0, 0);
        send_frame(fa, -1, 1'b1, "after reset arm", 0, 0, 0, 0, 0);
        send_frame(fa, -1, 1'b1, "after reset 1", 0, 0, 0, 0, 0);
        send_frame(fa, -1, 1'b1, "after reset lock", 12, 5, 9, 1, 1);

        $display("[TB] line end coincident with frame end");
        send_frame(fc, -1, 1'b0, "", 0, 0, 0, 0, 0);
        send_frame(fc, -1, 1'b1, "tight 1", 12, 5, 9, 0, 0);
        send_frame(fa, -1, 1'b1, "tight lock", 8, 6, 9, 1, 1);
        idle(20);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
